mos6502_int_sequencer: RTL and testbench

Interrupt/reset entry sequencer for the mos6502 core. It arbitrates RESET, NMI, IRQ and BRK requests and takes over the core's bus at an instruction boundary. It then drives the stack pushes of PCH, PCL and P, fetches the 16-bit vector, and hands the new PC, SP and I-flag update back to the core's register file. The core muxes this block's bus outputs onto add_bus/d_out/write_en whenever busy=1.

---
 rtl/mos6502_int_sequencer.sv | 152 +++++++++++++++
 tb/tb_mos6502_int_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mos6502_int_sequencer.sv
// Interrupt/reset entry sequencer: arbitrates RESET/NMI/IRQ/BRK at an instruction
// boundary, pushes PCH/PCL/P, fetches the vector and hands PC/SP/I back to the core.
module mos6502_int_sequencer #(
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] NMI_VEC    = 16'hFFFA,
  parameter logic [15:0] RST_VEC    = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC    = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rdy,
  input  logic        IRQ,
  input  logic        NMI,
  input  logic        brk_req,
  input  logic        sync,
  input  logic        i_flag,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  psr_in,
  input  logic [7:0]  d_in,
  output logic [15:0] add_bus,
  output logic [7:0]  d_out,
  output logic        write_en,
  output logic        busy,
  output logic [15:0] pc_out,
  output logic        pc_load,
  output logic [7:0]  sp_out,
  output logic        sp_load,
  output logic        set_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P, S_VEC_LO, S_VEC_HI, S_DONE
  } state_t;

  typedef enum logic [1:0] {K_RST, K_NMI, K_IRQ, K_BRK} kind_t;

  state_t      r_state, w_next;
  kind_t       r_kind, w_kind;
  logic [15:0] r_pc;
  logic [7:0]  r_sp, r_psr, r_lo, r_hi;
  logic        r_vec_nmi, r_rst_pending, r_nmi_pending, r_nmi_prev;
  logic        w_accept, w_nmi_edge, w_nmi_any, w_take_nmi, w_push;
  logic [15:0] w_vec;

  assign w_nmi_edge = ~NMI & r_nmi_prev;
  // A fresh edge counts in the same cycle so NMI beats a coincident IRQ.
  assign w_nmi_any  = r_nmi_pending | w_nmi_edge;
  assign w_take_nmi = (r_state == S_PUSH_P) && (r_kind != K_RST) && w_nmi_any;
  assign w_push     = (r_state == S_PUSH_PCH) || (r_state == S_PUSH_PCL) ||
                      (r_state == S_PUSH_P);
  assign w_vec      = (r_kind == K_RST) ? RST_VEC : (r_vec_nmi ? NMI_VEC : IRQ_VEC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_kind        <= K_RST;
      r_pc          <= 16'h0000;
      r_sp          <= 8'h00;
      r_psr         <= 8'h00;
      r_lo          <= 8'h00;
      r_hi          <= 8'h00;
      r_vec_nmi     <= 1'b0;
      r_rst_pending <= 1'b1;
      r_nmi_pending <= 1'b0;
      r_nmi_prev    <= 1'b1;
    end else begin
      r_nmi_prev    <= NMI;
      r_nmi_pending <= (r_nmi_pending | w_nmi_edge) & ~(rdy & w_take_nmi);
      if (rdy) begin
        r_state <= w_next;
        if (w_accept) begin
          r_kind    <= w_kind;
          r_pc      <= pc_in;
          r_sp      <= sp_in;
          r_psr     <= psr_in;
          r_vec_nmi <= 1'b0;
        end
        if (w_push) r_sp <= r_sp - 8'd1;
        if (r_state == S_PUSH_P) r_vec_nmi <= w_take_nmi;
        if (r_state == S_VEC_LO) r_lo <= d_in;
        if (r_state == S_VEC_HI) r_hi <= d_in;
        if (r_state == S_DONE && r_kind == K_RST) r_rst_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_kind   = r_kind;
    w_accept = 1'b0;
    add_bus  = 16'h0000;
    d_out    = 8'h00;
    write_en = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (r_rst_pending) begin
          w_accept = 1'b1;
          w_kind   = K_RST;
        end else if (sync) begin
          if (w_nmi_any) begin
            w_accept = 1'b1;
            w_kind   = K_NMI;
          end else if (!IRQ && !i_flag) begin
            w_accept = 1'b1;
            w_kind   = K_IRQ;
          end else if (brk_req) begin
            w_accept = 1'b1;
            w_kind   = K_BRK;
          end
        end
        if (w_accept) w_next = S_PUSH_PCH;
      end
      S_PUSH_PCH: begin
        w_next   = S_PUSH_PCL;
        add_bus  = {STACK_PAGE, r_sp};
        d_out    = r_pc[15:8];
        write_en = (r_kind == K_RST);
      end
      S_PUSH_PCL: begin
        w_next   = S_PUSH_P;
        add_bus  = {STACK_PAGE, r_sp};
        d_out    = r_pc[7:0];
        write_en = (r_kind == K_RST);
      end
      S_PUSH_P: begin
        w_next   = S_VEC_LO;
        add_bus  = {STACK_PAGE, r_sp};
        d_out    = {r_psr[7:6], 1'b1, (r_kind == K_BRK), r_psr[3:0]};
        write_en = (r_kind == K_RST);
      end
      S_VEC_LO: begin
        w_next  = S_VEC_HI;
        add_bus = w_vec;
      end
      S_VEC_HI: begin
        w_next  = S_DONE;
        add_bus = w_vec + 16'd1;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign busy    = (r_state != S_IDLE) | r_rst_pending;
  assign pc_out  = {r_hi, r_lo};
  assign sp_out  = r_sp;
  assign pc_load = (r_state == S_DONE);
  assign sp_load = (r_state == S_DONE);
  assign set_i   = (r_state == S_DONE);

endmodule

// File: tb/tb_mos6502_int_sequencer.sv
// Scoreboard bench for mos6502_int_sequencer: drivers queue expected bus cycles and
// completions from a transaction-level model; a negedge monitor pops and compares.
module tb_mos6502_int_sequencer;
  logic        clk = 1'b0;
  logic        reset, rdy, IRQ, NMI, brk_req, sync, i_flag;
  logic [15:0] pc_in, add_bus, pc_out;
  logic [7:0]  sp_in, psr_in, d_in, d_out, sp_out;
  logic        write_en, busy, pc_load, sp_load, set_i;

  mos6502_int_sequencer dut (
    .clk(clk), .reset(reset), .rdy(rdy), .IRQ(IRQ), .NMI(NMI), .brk_req(brk_req),
    .sync(sync), .i_flag(i_flag), .pc_in(pc_in), .sp_in(sp_in), .psr_in(psr_in),
    .d_in(d_in), .add_bus(add_bus), .d_out(d_out), .write_en(write_en), .busy(busy),
    .pc_out(pc_out), .pc_load(pc_load), .sp_out(sp_out), .sp_load(sp_load), .set_i(set_i)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  assign d_in = mem[add_bus];

  int n_chk = 0, n_err = 0;
  int cyc = 0, rcyc = 0, n_done = 0, last_done_wall = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rdy) rcyc <= rcyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm, input logic [31:0] act);
    n_chk++;
    n_err++;
    $display("FAIL %s: got %0h expected none (cycle %0d)", nm, act, cyc);
  endtask

  typedef struct {logic [15:0] a; logic we; logic [7:0] d;} bus_t;
  typedef struct {logic [15:0] pc; logic [7:0] sp; int rc;} done_t;
  bus_t  bus_q[$];
  done_t done_q[$];
  bus_t  eb;
  done_t ed;

  // Monitor: every owned bus cycle and every completion must match the queue head.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (busy === 1'b1 && add_bus !== 16'h0000) begin
        if (bus_q.size() == 0) fail("bus_unexpected", add_bus);
        else begin
          eb = bus_q[0];
          chk("bus_addr", add_bus, eb.a);
          chk("bus_we", write_en, eb.we);
          if (!eb.we) chk("bus_data", d_out, eb.d);
          if (rdy) void'(bus_q.pop_front());
        end
      end else if (write_en !== 1'b1) fail("stray_write", add_bus);
      if ((pc_load | sp_load | set_i) === 1'b1) begin
        if (done_q.size() == 0) fail("done_unexpected", pc_out);
        else begin
          ed = done_q[0];
          chk("pc_out", pc_out, ed.pc);
          chk("sp_out", sp_out, ed.sp);
          chk("pulses", {pc_load, sp_load, set_i}, 3'b111);
          chk("rdy_latency", rcyc, ed.rc);
          if (rdy) begin
            void'(done_q.pop_front());
            n_done++;
            last_done_wall = cyc;
          end
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_add_bus"}, add_bus, 16'h0000);
    chk({tag, "_d_out"}, d_out, 8'h00);
    chk({tag, "_write_en"}, write_en, 1'b1);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_pc_out"}, pc_out, 16'h0000);
    chk({tag, "_pulses"}, {pc_load, sp_load, set_i}, 3'b000);
  endtask

  // kind: 0 IRQ, 1 BRK, 2 NMI. stall: 0 none, 1 random, 2 three cycles in PUSH_PCL.
  // Called and returns at posedge+2.
  task automatic run_seq(input int kind, input logic [15:0] pc, input logic [7:0] sp,
                         input logic [7:0] psr, input int stall, input int nmi_at,
                         input int abort_k);
    logic [7:0]  p, s1, s2, s3;
    logic [15:0] v, v1;
    bit          hij, done;
    int          acc_wall, d0;
    hij  = (nmi_at >= 0) && (kind != 2);
    p    = psr;
    p[5] = 1'b1;
    p[4] = (kind == 1);
    v    = (kind == 2 || hij) ? 16'hFFFA : 16'hFFFE;
    v1   = v + 16'd1;
    s1   = sp - 8'd1;
    s2   = sp - 8'd2;
    s3   = sp - 8'd3;
    bus_q.push_back('{a: {8'h01, sp}, we: 1'b0, d: pc[15:8]});
    bus_q.push_back('{a: {8'h01, s1}, we: 1'b0, d: pc[7:0]});
    bus_q.push_back('{a: {8'h01, s2}, we: 1'b0, d: p});
    bus_q.push_back('{a: v, we: 1'b1, d: 8'h00});
    bus_q.push_back('{a: v1, we: 1'b1, d: 8'h00});
    done_q.push_back('{pc: {mem[v1], mem[v]}, sp: s3, rc: rcyc + 6});
    pc_in = pc; sp_in = sp; psr_in = psr; rdy = 1'b1; sync = 1'b1;
    case (kind)
      0: begin IRQ = 1'b0; i_flag = 1'b0; end
      1: brk_req = 1'b1;
      default: NMI = 1'b0;
    endcase
    d0 = n_done;
    @(posedge clk); #2;
    acc_wall = cyc;
    sync = 1'b0; brk_req = 1'b0; IRQ = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      if (k == abort_k) begin
        reset = 1'b0;
        break;
      end
      if (k == nmi_at) NMI = 1'b0;
      case (stall)
        1:       rdy = ($urandom_range(0, 3) != 0);
        2:       rdy = !(k >= 1 && k <= 3);
        default: rdy = 1'b1;
      endcase
      @(posedge clk); #2;
      if (n_done != d0) done = 1'b1;
    end
    rdy = 1'b1;
    if (abort_k < 0) begin
      chk("seq_done", done, 1'b1);
      if (stall != 1) chk("wall_latency", last_done_wall - acc_wall, (stall == 2) ? 8 : 5);
    end
  endtask

  // Releases reset (must be low on entry) and expects a write-free RST sequence.
  task automatic run_rst(input logic [7:0] sp);
    logic [7:0] s1, s2, s3;
    bit         done;
    int         d0;
    s1 = sp - 8'd1; s2 = sp - 8'd2; s3 = sp - 8'd3;
    bus_q.push_back('{a: {8'h01, sp}, we: 1'b1, d: 8'h00});
    bus_q.push_back('{a: {8'h01, s1}, we: 1'b1, d: 8'h00});
    bus_q.push_back('{a: {8'h01, s2}, we: 1'b1, d: 8'h00});
    bus_q.push_back('{a: 16'hFFFC, we: 1'b1, d: 8'h00});
    bus_q.push_back('{a: 16'hFFFD, we: 1'b1, d: 8'h00});
    done_q.push_back('{pc: {mem[16'hFFFD], mem[16'hFFFC]}, sp: s3, rc: rcyc + 6});
    sp_in = sp; sync = 1'b0; rdy = 1'b1; reset = 1'b1;
    d0 = n_done;
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(posedge clk); #2;
      if (n_done != d0) done = 1'b1;
    end
    chk("rst_done", done, 1'b1);
    chk("rst_busy_after", busy, 1'b0);
  endtask

  task automatic idle_sync(input int n);
    sync = 1'b1;
    repeat (n) begin @(posedge clk); #2; end
    chk("no_entry_busy", busy, 1'b0);
    sync = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; rdy = 1'b1; IRQ = 1'b1; NMI = 1'b1; brk_req = 1'b0; sync = 1'b0;
    i_flag = 1'b0; pc_in = 16'h0; sp_in = 8'h00; psr_in = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'hC0;
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h80;
    repeat (3) @(posedge clk);
    #2;
    chk_reset("por");
    run_rst(8'h00);

    run_seq(0, 16'h1234, 8'hFF, 8'h81, 0, -1, -1);
    repeat (2) begin @(posedge clk); #2; end

    IRQ = 1'b0; i_flag = 1'b1;
    idle_sync(4);
    IRQ = 1'b1;
    run_seq(1, 16'h1234, 8'hFF, 8'h81, 0, -1, -1);
    repeat (2) begin @(posedge clk); #2; end

    // IRQ hijacked by an NMI falling in PUSH_PCL; NMI then held low.
    i_flag = 1'b0;
    run_seq(0, 16'hBEEF, 8'h40, 8'h00, 0, 1, -1);
    idle_sync(5);
    NMI = 1'b1;
    repeat (2) begin @(posedge clk); #2; end

    run_seq(0, 16'h5A5A, 8'h02, 8'hFF, 2, -1, -1);
    repeat (2) begin @(posedge clk); #2; end

    // Reset during VEC_LO of an IRQ.
    run_seq(0, 16'hCAFE, 8'h80, 8'h10, 0, -1, 3);
    #1;
    chk("abort_remaining", bus_q.size(), 2);
    bus_q.delete();
    done_q.delete();
    chk_reset("abort");
    @(posedge clk); #2;
    run_rst(8'($urandom));

    for (int it = 0; it < 30; it++) begin
      int kind, nat;
      kind = $urandom_range(0, 3);
      for (int a = 16'hFFFA; a <= 16'hFFFF; a++) mem[a] = 8'($urandom);
      if (kind == 3) begin
        IRQ = 1'b0; i_flag = 1'b1;
        idle_sync(2);
        IRQ = 1'b1;
      end else begin
        nat = (kind != 2 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2)) : -1;
        if (kind != 0) i_flag = 1'($urandom);
        run_seq(kind, 16'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(0, 2), nat, -1);
        NMI = 1'b1;
      end
      repeat (2) begin @(posedge clk); #2; end
    end

    repeat (3) begin @(posedge clk); #2; end
    chk("bus_q_empty", bus_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
